// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that drives the control pins of an external N-bit LFSR.
// It runs seeded shift jobs and returns the final LFSR state over a valid/ready port.
module lfsr_seq_ctrl #(
    parameter int unsigned N  = 26,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          r,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_seed,
    input  logic [CW-1:0] req_cycles,
    input  logic          abort,
    output logic          lfsr_r,
    output logic          lfsr_load,
    output logic [3:0]    lfsr_s,
    input  logic [N-1:0]  lfsr_q,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          busy,
    output logic          err
);

    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_HOLD    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] seed_q, seed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lfsr_r_q, lfsr_r_d;
    logic          lfsr_load_q, lfsr_load_d;
    logic [SW-1:0] lfsr_s_q, lfsr_s_d;
    logic          res_valid_q, res_valid_d;
    logic [N-1:0]  res_data_q, res_data_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          abortable;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            cnt_q       <= '0;
            lfsr_r_q    <= 1'b1;
            lfsr_load_q <= 1'b0;
            lfsr_s_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            cnt_q       <= cnt_d;
            lfsr_r_q    <= lfsr_r_d;
            lfsr_load_q <= lfsr_load_d;
            lfsr_s_q    <= lfsr_s_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign abortable = (state_q == S_CLEAR) || (state_q == S_LOAD) ||
                       (state_q == S_RUN)   || (state_q == S_CAPTURE);

    // Next state; control pins are decoded from the next state so they are registered.
    always_comb begin
        state_d     = state_q;
        seed_d      = seed_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_seed != '0) begin
                        seed_d  = req_seed;
                        cnt_d   = req_cycles;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: state_d = S_LOAD;
            S_LOAD:  state_d = (cnt_q != '0) ? S_RUN : S_CAPTURE;
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_data_d  = lfsr_q;
                res_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything up to and including the capture cycle
        if (abort && abortable) begin
            state_d     = S_IDLE;
            err_d       = 1'b1;
            res_valid_d = 1'b0;
            res_data_d  = res_data_q;
        end

        lfsr_r_d    = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_HOLD);
        lfsr_load_d = (state_d == S_LOAD);
        lfsr_s_d    = (state_d == S_LOAD) ? seed_d : '0;
        busy_d      = (state_d != S_IDLE);
    end

    assign req_ready = (state_q == S_IDLE);
    assign lfsr_r    = lfsr_r_q;
    assign lfsr_load = lfsr_load_q;
    assign lfsr_s    = lfsr_s_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Self-checking bench for lfsr_seq_ctrl driving a behavioural LFSR plant.
module tb_lfsr_seq_ctrl;

    localparam int unsigned N  = 26;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          r;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_seed;
    logic [CW-1:0] req_cycles;
    logic          abort;
    logic          lfsr_r;
    logic          lfsr_load;
    logic [3:0]    lfsr_s;
    logic [N-1:0]  lfsr_q;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;
    logic          busy;
    logic          err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .r          (r),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_seed   (req_seed),
        .req_cycles (req_cycles),
        .abort      (abort),
        .lfsr_r     (lfsr_r),
        .lfsr_load  (lfsr_load),
        .lfsr_s     (lfsr_s),
        .lfsr_q     (lfsr_q),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .err        (err)
    );

    // Controlled LFSR: sync clear, low-nibble load, Galois shift with feedback into bits 1, 2, 6
    always @(posedge clk) begin
        if (lfsr_r)         lfsr_q <= '0;
        else if (lfsr_load) lfsr_q <= {lfsr_q[N-1:4], lfsr_s};
        else                lfsr_q <= {lfsr_q[N-2:0], 1'b0} ^ ({N{lfsr_q[N-1]}} & 26'h0000046);
    end

    // Expected state as polynomial doubling modulo the feedback rule, in plain integers
    function automatic logic [N-1:0] ref_lfsr(input logic [3:0] seed, input int unsigned cyc);
        longint unsigned v;
        longint unsigned top;
        v   = 64'(seed);
        top = 64'd1 << N;
        for (int unsigned i = 0; i < cyc; i++) begin
            v = v * 2;
            if (v >= top) v = (v - top) ^ 64'h46;
        end
        return N'(v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One job; abort_k != 0 raises abort in the abort_k-th cycle after the accept edge
    task automatic run_job(input logic [3:0] seed, input int unsigned cyc,
                           input int unsigned abort_k, input int unsigned stall,
                           input logic [N-1:0] exp_q);
        int unsigned last_k;
        bit          hold;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_seed   = seed;
        req_cycles = CW'(cyc);
        res_ready  = (stall == 0);
        @(negedge clk);
        req_valid  = 1'b0;
        req_seed   = 4'($urandom);
        req_cycles = CW'($urandom);
        last_k = (abort_k != 0) ? abort_k : cyc + 4 + stall;
        for (int unsigned k = 1; k <= last_k; k++) begin
            hold = (k >= cyc + 4);
            chk("busy",      32'(busy),      32'd1);
            chk("req_ready", 32'(req_ready), 32'd0);
            chk("err",       32'(err),       32'd0);
            chk("lfsr_r",    32'(lfsr_r),    32'((k == 1) || hold));
            chk("lfsr_load", 32'(lfsr_load), 32'(k == 2));
            chk("lfsr_s",    32'(lfsr_s),    32'((k == 2) ? seed : 4'd0));
            chk("res_valid", 32'(res_valid), 32'(hold));
            if (hold) chk("res_data", 32'(res_data), 32'(exp_q));
            if (abort_k != 0 && k == abort_k) abort = 1'b1;
            if (hold) begin
                abort = 1'($urandom);
                if (k == cyc + 4 + stall) res_ready = 1'b1;
            end
            @(negedge clk);
        end
        abort     = 1'b0;
        res_ready = 1'b0;
        chk("end_busy",   32'(busy),      32'd0);
        chk("end_ready",  32'(req_ready), 32'd1);
        chk("end_lfsr_r", 32'(lfsr_r),    32'd1);
        chk("end_valid",  32'(res_valid), 32'd0);
        chk("end_err",    32'(err),       32'(abort_k != 0));
        @(negedge clk);
        chk("err_pulse",  32'(err),       32'd0);
        chk("no_result",  32'(res_valid), 32'd0);
    endtask

    task automatic zero_seed();
        @(negedge clk);
        req_valid  = 1'b1;
        req_seed   = 4'd0;
        req_cycles = CW'($urandom);
        @(negedge clk);
        req_valid = 1'b0;
        chk("zs_err",   32'(err),       32'd1);
        chk("zs_busy",  32'(busy),      32'd0);
        chk("zs_ready", 32'(req_ready), 32'd1);
        chk("zs_load",  32'(lfsr_load), 32'd0);
        chk("zs_r",     32'(lfsr_r),    32'd1);
        @(negedge clk);
        chk("zs_err_clr", 32'(err),       32'd0);
        chk("zs_load2",   32'(lfsr_load), 32'd0);
        chk("zs_busy2",   32'(busy),      32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_lfsr_r"},    32'(lfsr_r),    32'd1);
        chk({tag, "_load"},      32'(lfsr_load), 32'd0);
        chk({tag, "_s"},         32'(lfsr_s),    32'd0);
        chk({tag, "_ready"},     32'(req_ready), 32'd1);
        chk({tag, "_valid"},     32'(res_valid), 32'd0);
        chk({tag, "_data"},      32'(res_data),  32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  s;
        int unsigned c;
        int unsigned ak;
        r          = 1'b0;
        req_valid  = 1'b0;
        req_seed   = 4'd0;
        req_cycles = '0;
        abort      = 1'b0;
        res_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        r = 1'b1;

        run_job(4'd1, 0,  0, 0, 26'h0000001);
        run_job(4'd1, 3,  0, 0, 26'h0000008);
        run_job(4'd1, 26, 0, 0, 26'h0000046);
        run_job(4'd1, 5,  0, 7, 26'h0000020);
        zero_seed();
        run_job(4'd3, 10, 6, 0, '0);
        run_job(4'hb, 255, 0, 1, ref_lfsr(4'hb, 255));

        for (int j = 0; j < 30; j++) begin
            s = 4'($urandom);
            c = $urandom_range(0, 40);
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, c + 3) : 0;
            if (s == 4'd0) zero_seed();
            else run_job(s, c, ak, $urandom_range(0, 3), ref_lfsr(s, c));
        end

        // Asynchronous reset while the LFSR is shifting
        @(negedge clk);
        req_valid  = 1'b1;
        req_seed   = 4'd3;
        req_cycles = CW'(20);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_arst_busy", 32'(busy), 32'd1);
        #2 r = 1'b0;
        #1;
        check_reset_values("arst");
        @(negedge clk);
        r = 1'b1;
        run_job(4'd2, 1, 0, 0, 26'h0000004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
